// File: rtl/ram_write_buffer.sv
// ram_write_buffer: buffers byte/halfword/word RAM writes and drains them to a 32-bit SRAM with fixed wait states
module ram_write_buffer #(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        wr_sig_write,
    input  logic [31:0]       wr_address,
    input  logic [31:0]       wr_data,
    output logic              wr_is_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_we,
    output logic              idle,
    output logic              err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     wp, rp, rp_sel;
    logic [CW-1:0]     count, count_n;
    logic [3:0]        wcnt, wcnt_n;
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [31:0]       q_wdata [DEPTH];
    logic [3:0]        q_be [DEPTH];
    logic              accept, bad, push, pop, load, bypass;
    logic [ADDR_W-1:0] in_addr, ld_addr;
    logic [31:0]       in_wdata, ld_wdata;
    logic [3:0]        in_be, ld_be;

    // validate the request and steer it onto byte lanes
    always_comb begin
        accept   = (wr_sig_write != 2'd0) && wr_is_ready;
        bad      = (wr_sig_write == 2'd2 && wr_address[0]) ||
                   (wr_sig_write == 2'd3 && wr_address[1:0] != 2'd0) ||
                   ((wr_address >> (ADDR_W + 2)) != 32'd0);
        push     = accept && !bad;
        in_addr  = wr_address[ADDR_W+1:2];
        in_wdata = wr_sig_write == 2'd1 ? {4{wr_data[7:0]}} :
                   wr_sig_write == 2'd2 ? {2{wr_data[15:0]}} : wr_data;
        in_be    = wr_sig_write == 2'd1 ? 4'b0001 << wr_address[1:0] :
                   wr_sig_write == 2'd2 ? (wr_address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

    // drain FSM; a same-cycle push into a one-entry FIFO is bypassed so back-to-back writes keep going
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        pop     = 1'b0;
        load    = 1'b0;
        if (state == S_IDLE) begin
            if (count != '0) begin
                load    = 1'b1;
                wcnt_n  = 4'd0;
                state_n = S_WRITE;
            end
        end else if (wcnt == 4'(WAIT_STATES)) begin
            pop    = 1'b1;
            wcnt_n = 4'd0;
            if (count > CW'(1) || push) load = 1'b1;
            else state_n = S_IDLE;
        end else begin
            wcnt_n = wcnt + 4'd1;
        end
        count_n  = count + CW'(push) - CW'(pop);
        rp_sel   = state == S_WRITE ? rp + PW'(1) : rp;
        bypass   = state == S_WRITE && count == CW'(1);
        ld_addr  = bypass ? in_addr : q_addr[rp_sel];
        ld_wdata = bypass ? in_wdata : q_wdata[rp_sel];
        ld_be    = bypass ? in_be : q_be[rp_sel];
    end

    // FIFO storage; contents need no reset because count qualifies them
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wp]  <= in_addr;
            q_wdata[wp] <= in_wdata;
            q_be[wp]    <= in_be;
        end
    end

    // state, pointers, status flags and the registered SRAM port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wcnt        <= 4'd0;
            count       <= '0;
            wp          <= '0;
            rp          <= '0;
            wr_is_ready <= 1'b1;
            idle        <= 1'b1;
            err         <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'd0;
            mem_addr    <= '0;
            mem_wdata   <= 32'd0;
        end else begin
            state       <= state_n;
            wcnt        <= wcnt_n;
            count       <= count_n;
            wp          <= wp + PW'(push);
            rp          <= rp + PW'(pop);
            wr_is_ready <= count_n != CW'(DEPTH);
            idle        <= count_n == '0 && state_n == S_IDLE;
            err         <= err | (accept && bad);
            mem_we      <= state_n == S_WRITE;
            if (load) begin
                mem_addr  <= ld_addr;
                mem_wdata <= ld_wdata;
                mem_be    <= ld_be;
            end else if (state_n == S_IDLE) begin
                mem_be <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_ram_write_buffer.sv
// tb_ram_write_buffer: randomized and directed checks of ram_write_buffer against a byte-level memory model
module tb_ram_write_buffer;
    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } entry_t;

    logic        clk = 1'b0, reset_n = 1'b0, sel = 1'b0;
    logic [1:0]  sig = 2'd0;
    logic [31:0] addr = 32'd0, data = 32'd0;
    logic [1:0]  sig_a, sig_b;
    logic        ready_a, we_a, idle_a, err_a, ready_b, we_b, idle_b, err_b;
    logic [15:0] maddr_a, maddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic [3:0]  be_a, be_b;
    logic        ready, we, idle, err;
    logic [15:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;

    entry_t      exp_q[$], act_q[$], cur;
    logic [7:0]  exp_b[int], act_b[int];
    logic        err_exp;
    int          tests = 0, fails = 0, run = 0, we_cycles = 0, first = -1, last = -1, cyc = 0;

    assign sig_a = sel ? 2'd0 : sig;
    assign sig_b = sel ? sig : 2'd0;
    assign ready = sel ? ready_b : ready_a;
    assign we    = sel ? we_b : we_a;
    assign idle  = sel ? idle_b : idle_a;
    assign err   = sel ? err_b : err_a;
    assign maddr = sel ? maddr_b : maddr_a;
    assign wdata = sel ? wdata_b : wdata_a;
    assign be    = sel ? be_b : be_a;

    ram_write_buffer #(.DEPTH(4), .ADDR_W(16), .WAIT_STATES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .wr_sig_write(sig_a), .wr_address(addr), .wr_data(data),
        .wr_is_ready(ready_a), .mem_addr(maddr_a), .mem_wdata(wdata_a), .mem_be(be_a),
        .mem_we(we_a), .idle(idle_a), .err(err_a));

    ram_write_buffer #(.DEPTH(4), .ADDR_W(16), .WAIT_STATES(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_sig_write(sig_b), .wr_address(addr), .wr_data(data),
        .wr_is_ready(ready_b), .mem_addr(maddr_b), .mem_wdata(wdata_b), .mem_be(be_b),
        .mem_we(we_b), .idle(idle_b), .err(err_b));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // SRAM-side monitor: each write must hold mem_* steady for exactly WAIT_STATES+1 strobe cycles
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            run = 0;
            we_cycles = 0;
            first = -1;
            last = -1;
            act_q.delete();
            act_b.delete();
        end else if (we === 1'b1) begin
            we_cycles++;
            if (first < 0) first = cyc;
            last = cyc;
            if (run == 0) cur = {maddr, wdata, be};
            else begin
                tests++;
                if ({maddr, wdata, be} !== cur) begin
                    fails++;
                    $display("FAIL mem_hold: got %h want %h", {maddr, wdata, be}, cur);
                end
            end
            run++;
            if (run == (sel ? 4 : 2)) begin
                act_q.push_back(cur);
                for (int k = 0; k < 4; k++) if (cur.be[k]) act_b[int'(cur.a) * 4 + k] = cur.d[8*k+:8];
                run = 0;
            end
        end else if (run != 0) begin
            tests++;
            fails++;
            $display("FAIL mem_we_short: strobe dropped after %0d cycles, want %0d", run, sel ? 4 : 2);
            run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic s);
        reset_n = 1'b0;
        sig = 2'd0;
        addr = 32'd0;
        data = 32'd0;
        sel = s;
        exp_q.delete();
        exp_b.delete();
        err_exp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    // present a request, hold it until accepted, and apply the byte-level model
    task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, output bit waited);
        int n, c, off;
        entry_t e;
        waited = 0;
        c = 0;
        sig = sz;
        addr = a;
        data = d;
        while (ready !== 1'b1 && c < 200) begin
            waited = 1;
            tick();
            c++;
        end
        if (ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, want 1", ready, c);
            sig = 2'd0;
            return;
        end
        tick();
        sig = 2'd0;
        n = sz == 2'd1 ? 1 : sz == 2'd2 ? 2 : 4;
        off = int'(a[1:0]);
        if (a % n == 0 && a < 32'h40000) begin
            e.a = a[17:2];
            for (int k = 0; k < 4; k++) begin
                e.d[8*k+:8] = d[8*(k % n)+:8];
                e.be[k] = k >= off && k < off + n;
            end
            exp_q.push_back(e);
            for (int j = 0; j < n; j++) exp_b[int'(a) + j] = d[8*j+:8];
        end else begin
            err_exp = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        tick();
        while (!(idle === 1'b1 && we === 1'b0) && c < 3000) begin
            tick();
            c++;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        tests++;
        if ({ready_a, we_a, be_a, maddr_a, wdata_a, idle_a, err_a} !== {1'b1, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_a: got rdy=%b we=%b be=%b addr=%h wd=%h idle=%b err=%b, want 1 0 0000 0000 00000000 1 0",
                     ready_a, we_a, be_a, maddr_a, wdata_a, idle_a, err_a);
        end
        tests++;
        if ({ready_b, we_b, be_b, maddr_b, wdata_b, idle_b, err_b} !== {1'b1, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_b: got rdy=%b we=%b be=%b addr=%h wd=%h idle=%b err=%b, want 1 0 0000 0000 00000000 1 0",
                     ready_b, we_b, be_b, maddr_b, wdata_b, idle_b, err_b);
        end
    endtask

    task automatic test_halfword_basic();
        do_reset(1'b0);
        sig = 2'd2;
        addr = 32'h2;
        data = 32'h3412;
        tick();
        sig = 2'd0;
        tests++;
        if (we !== 1'b0) begin fails++; $display("FAIL hw_accept_cycle: we=%b want 0", we); end
        tick();
        tests++;
        if ({we, maddr, wdata, be} !== {1'b1, 16'h0, 32'h34123412, 4'b1100}) begin
            fails++;
            $display("FAIL hw_first: got we=%b addr=%h wd=%h be=%b, want 1 0000 34123412 1100", we, maddr, wdata, be);
        end
        tick();
        tests++;
        if (we !== 1'b1) begin fails++; $display("FAIL hw_second: we=%b want 1", we); end
        tick();
        tests++;
        if ({we, be} !== {1'b0, 4'b0}) begin fails++; $display("FAIL hw_end: we=%b be=%b want 0 0000", we, be); end
        tick();
        tests++;
        if ({idle, err} !== 2'b10) begin fails++; $display("FAIL hw_idle: idle=%b err=%b want 1 0", idle, err); end
    endtask

    task automatic test_byte_lanes();
        bit w;
        do_reset(1'b0);
        send(2'd1, 32'h1001, 32'h556677AB, w);
        send(2'd1, 32'h1003, 32'h112233CD, w);
        wait_idle();
        tests++;
        if (act_q.size() != 2) begin
            fails++;
            $display("FAIL byte_count: got %0d writes want 2", act_q.size());
        end else begin
            tests++;
            if (act_q[0] !== {16'h0400, 32'hABABABAB, 4'b0010}) begin
                fails++;
                $display("FAIL byte_first: got %h want %h", act_q[0], {16'h0400, 32'hABABABAB, 4'b0010});
            end
            tests++;
            if (act_q[1] !== {16'h0400, 32'hCDCDCDCD, 4'b1000}) begin
                fails++;
                $display("FAIL byte_second: got %h want %h", act_q[1], {16'h0400, 32'hCDCDCDCD, 4'b1000});
            end
        end
    endtask

    task automatic test_boot_pattern();
        bit w;
        int lows = 0;
        logic [31:0] aw, ew;
        do_reset(1'b0);
        for (int i = 0; i < 256; i++) begin
            send(2'd2, 32'(2 * i), $urandom(), w);
            lows += int'(w);
            repeat (8) tick();
        end
        wait_idle();
        tests++;
        if (lows != 0) begin fails++; $display("FAIL boot_ready: ready low before %0d requests, want 0", lows); end
        for (int i = 0; i < 128; i++) begin
            for (int k = 0; k < 4; k++) begin
                aw[8*k+:8] = act_b.exists(4 * i + k) ? act_b[4 * i + k] : 8'hxx;
                ew[8*k+:8] = exp_b[4 * i + k];
            end
            tests++;
            if (aw !== ew) begin fails++; $display("FAIL boot_word[%0d]: got %h want %h", i, aw, ew); end
        end
        tests++;
        if (idle !== 1'b1) begin fails++; $display("FAIL boot_idle: idle=%b want 1", idle); end
    endtask

    task automatic test_back_to_back();
        bit w;
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            send(2'd3, 32'h100 + 32'(4 * i), $urandom(), w);
            if (i < 4) begin
                tests++;
                if (ready !== (i < 3)) begin
                    fails++;
                    $display("FAIL b2b_ready[%0d]: ready=%b want %b", i, ready, i < 3);
                end
            end
        end
        wait_idle();
        tests++;
        if (we_cycles != 24 || last - first + 1 != 24) begin
            fails++;
            $display("FAIL b2b_continuous: strobe cycles=%0d span=%0d, want 24 24", we_cycles, last - first + 1);
        end
        tests++;
        if (act_q.size() != 6) begin
            fails++;
            $display("FAIL b2b_count: got %0d writes want 6", act_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_order[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_errors();
        bit w;
        logic [1:0]  sz[5] = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd1};
        logic [31:0] ad[5] = '{32'h5, 32'h2, 32'h40000, 32'h3FFFC, 32'h3FFFF};
        for (int i = 0; i < 5; i++) begin
            do_reset(1'b0);
            send(sz[i], ad[i], $urandom(), w);
            tests++;
            if (err !== err_exp || ready !== 1'b1) begin
                fails++;
                $display("FAIL err_flag[%0d]: err=%b ready=%b want %b 1", i, err, ready, err_exp);
            end
            repeat (6) tick();
            tests++;
            if (act_q.size() != exp_q.size() || we_cycles != 2 * exp_q.size()) begin
                fails++;
                $display("FAIL err_writes[%0d]: writes=%0d strobes=%0d want %0d %0d", i, act_q.size(), we_cycles,
                         exp_q.size(), 2 * exp_q.size());
            end else if (exp_q.size() == 1) begin
                tests++;
                if (act_q[0] !== exp_q[0]) begin fails++; $display("FAIL err_edge[%0d]: got %h want %h", i, act_q[0], exp_q[0]); end
            end
        end
        do_reset(1'b0);
        send(2'd2, 32'h5, 32'h1234, w);
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL err_seq_first: err=%b want 1", err); end
        send(2'd3, 32'h2, 32'h1234, w);
        send(2'd1, 32'h40000, 32'h12, w);
        repeat (6) tick();
        tests++;
        if (err !== 1'b1 || ready !== 1'b1 || we_cycles != 0) begin
            fails++;
            $display("FAIL err_seq: err=%b ready=%b strobes=%0d want 1 1 0", err, ready, we_cycles);
        end
    endtask

    task automatic test_reset_mid_write();
        bit w;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) send(2'd3, 32'h200 + 32'(4 * i), $urandom(), w);
        tests++;
        if (we !== 1'b1) begin fails++; $display("FAIL rst_pre: we=%b want 1", we); end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({we, be, idle, ready} !== {1'b0, 4'b0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL rst_async: we=%b be=%b idle=%b ready=%b want 0 0000 1 1", we, be, idle, ready);
        end
        do_reset(1'b1);
        repeat (30) tick();
        tests++;
        if (we_cycles != 0 || act_q.size() != 0 || idle !== 1'b1) begin
            fails++;
            $display("FAIL rst_residual: strobes=%0d writes=%0d idle=%b want 0 0 1", we_cycles, act_q.size(), idle);
        end
    endtask

    task automatic test_random(input logic s);
        bit w;
        logic [1:0]  sz;
        logic [31:0] a;
        do_reset(s);
        repeat (60) begin
            sz = 2'($urandom_range(1, 3));
            a = $urandom_range(0, 9) == 0 ? 32'h40000 + $urandom_range(0, 255) : $urandom_range(0, 127);
            send(sz, a, $urandom(), w);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        tests++;
        if (act_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand%0d_count: got %0d writes want %0d", s, act_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests++;
                if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_write[%0d]: got %h want %h", s, i, act_q[i], exp_q[i]); end
            end
        end
        foreach (exp_b[i]) begin
            tests++;
            if (!act_b.exists(i) || act_b[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL rand%0d_byte[%0d]: got %h want %h", s, i, act_b.exists(i) ? act_b[i] : 8'hxx, exp_b[i]);
            end
        end
        tests++;
        if (err !== err_exp) begin fails++; $display("FAIL rand%0d_err: err=%b want %b", s, err, err_exp); end
    endtask

    initial begin
        test_reset();
        test_halfword_basic();
        test_byte_lanes();
        test_boot_pattern();
        test_back_to_back();
        test_errors();
        test_reset_mid_write();
        test_random(1'b0);
        test_random(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
